// File: rtl/snn_feeder.sv
// snn_feeder: collects one pattern of image/kernel/weight/option words from a
// valid/ready load stream, replays it to the SNN core as one in_valid burst, then waits for out_valid.
module snn_feeder #(
    parameter int IMG_LEN = 72,
    parameter int KER_LEN = 27,
    parameter int WGT_LEN = 4,
    parameter int TIMEOUT = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [1:0]  s_type,
    input  logic [31:0] s_data,
    output logic        in_valid,
    output logic [31:0] Img,
    output logic [31:0] Kernel,
    output logic [31:0] Weight,
    output logic [1:0]  Opt,
    input  logic        snn_out_valid,
    output logic        done,
    output logic        err
);
    localparam int IW = $clog2(IMG_LEN + 1);
    localparam int KW = $clog2(KER_LEN + 1);
    localparam int WW = $clog2(WGT_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int IA = (IMG_LEN > 1) ? $clog2(IMG_LEN) : 1;
    localparam int KA = (KER_LEN > 1) ? $clog2(KER_LEN) : 1;
    localparam int WA = (WGT_LEN > 1) ? $clog2(WGT_LEN) : 1;

    typedef enum logic [1:0] {LOAD, SEND, WAIT} state_t;
    state_t state, state_n;

    logic [31:0]   img_buf [IMG_LEN];
    logic [31:0]   ker_buf [KER_LEN];
    logic [31:0]   wgt_buf [WGT_LEN];
    logic [1:0]    opt_reg;

    logic [IW-1:0] img_cnt, idx;
    logic [KW-1:0] ker_cnt;
    logic [WW-1:0] wgt_cnt;
    logic          opt_cnt;
    logic [TW-1:0] wait_cnt;

    logic          img_full, ker_full, wgt_full, accept, all_full_n, timeout_hit;
    logic          in_valid_n, done_n, err_n;
    logic [31:0]   img_n, ker_n, wgt_n;
    logic [1:0]    opt_n;

    assign img_full    = (img_cnt == IW'(IMG_LEN));
    assign ker_full    = (ker_cnt == KW'(KER_LEN));
    assign wgt_full    = (wgt_cnt == WW'(WGT_LEN));
    assign timeout_hit = (wait_cnt == TW'(TIMEOUT - 1));

    always_comb begin
        s_ready = 1'b0;
        if (state == LOAD) begin
            case (s_type)
                2'd0:    s_ready = !img_full;
                2'd1:    s_ready = !ker_full;
                2'd2:    s_ready = !wgt_full;
                default: s_ready = !opt_cnt;
            endcase
        end
    end

    assign accept = s_valid && s_ready;

    // True when every type will be complete once this cycle's accepted word is counted.
    assign all_full_n =
        (img_full || (accept && s_type == 2'd0 && img_cnt == IW'(IMG_LEN - 1))) &&
        (ker_full || (accept && s_type == 2'd1 && ker_cnt == KW'(KER_LEN - 1))) &&
        (wgt_full || (accept && s_type == 2'd2 && wgt_cnt == WW'(WGT_LEN - 1))) &&
        (opt_cnt  || (accept && s_type == 2'd3));

    always_ff @(posedge clk) begin
        if (rst) state <= LOAD;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            LOAD:    if (accept && all_full_n) state_n = SEND;
            SEND:    if (idx == IW'(IMG_LEN)) state_n = WAIT;
            WAIT:    if (snn_out_valid || timeout_hit) state_n = LOAD;
            default: state_n = LOAD;
        endcase
    end

    // Beat 0 is registered on the final accept edge, so the just-accepted word is forwarded.
    always_comb begin
        in_valid_n = 1'b0;
        img_n      = '0;
        ker_n      = '0;
        wgt_n      = '0;
        opt_n      = '0;
        done_n     = 1'b0;
        err_n      = err;
        case (state)
            LOAD: if (state_n == SEND) begin
                in_valid_n = 1'b1;
                img_n = (s_type == 2'd0 && img_cnt == '0) ? s_data : img_buf[0];
                ker_n = (s_type == 2'd1 && ker_cnt == '0) ? s_data : ker_buf[0];
                wgt_n = (s_type == 2'd2 && wgt_cnt == '0) ? s_data : wgt_buf[0];
                opt_n = (s_type == 2'd3) ? s_data[1:0] : opt_reg;
            end
            SEND: if (state_n == SEND) begin
                in_valid_n = 1'b1;
                img_n = img_buf[idx[IA-1:0]];
                if (idx < IW'(KER_LEN)) ker_n = ker_buf[idx[KA-1:0]];
                if (idx < IW'(WGT_LEN)) wgt_n = wgt_buf[idx[WA-1:0]];
            end
            WAIT: begin
                if (snn_out_valid)    done_n = 1'b1;
                else if (timeout_hit) err_n  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_valid <= 1'b0;
            Img      <= '0;
            Kernel   <= '0;
            Weight   <= '0;
            Opt      <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            img_cnt  <= '0;
            ker_cnt  <= '0;
            wgt_cnt  <= '0;
            opt_cnt  <= 1'b0;
            idx      <= '0;
            wait_cnt <= '0;
        end else begin
            in_valid <= in_valid_n;
            Img      <= img_n;
            Kernel   <= ker_n;
            Weight   <= wgt_n;
            Opt      <= opt_n;
            done     <= done_n;
            err      <= err_n;
            idx      <= (state == SEND) ? idx + IW'(1) : IW'(1);
            wait_cnt <= (state == WAIT) ? wait_cnt + TW'(1) : '0;
            if (state == WAIT && state_n == LOAD) begin
                img_cnt <= '0;
                ker_cnt <= '0;
                wgt_cnt <= '0;
                opt_cnt <= 1'b0;
            end else if (accept) begin
                case (s_type)
                    2'd0:    img_cnt <= img_cnt + IW'(1);
                    2'd1:    ker_cnt <= ker_cnt + KW'(1);
                    2'd2:    wgt_cnt <= wgt_cnt + WW'(1);
                    default: opt_cnt <= 1'b1;
                endcase
            end
        end
    end

    // Buffers survive reset; the next load overwrites every entry before it is replayed.
    always_ff @(posedge clk) begin
        if (!rst && accept) begin
            case (s_type)
                2'd0:    img_buf[img_cnt[IA-1:0]] <= s_data;
                2'd1:    ker_buf[ker_cnt[KA-1:0]] <= s_data;
                2'd2:    wgt_buf[wgt_cnt[WA-1:0]] <= s_data;
                default: opt_reg <= s_data[1:0];
            endcase
        end
    end
endmodule
